custom_axi_ip_mc: RTL
=====================

Name: custom_axi_ip_mc

Overview:
Multi-channel, parametrised successor to the single-channel register-driven compute engine. NUM_CH independent channels each capture a data word from their register on enable and apply a selectable arithmetic op for BUSY_CYCLES iterations. Overflow or underflow sends the channel to ERROR. Finished results share a single write-back port through a round-robin arbiter. Sits between the AXI register file (inputs) and the result/status registers (outputs).

Parameters:
DATA_WIDTH, 32, width of data words and step
NUM_CH, 4, number of independent channels (>=1)
BUSY_CYCLES, 1, op iterations per job (>=1)
CH_W, max(1,$clog2(NUM_CH)), derived, channel index width

Ports:
clk_i  in  1  clock, all logic on rising edge
rst_i  in  1  reset, synchronous, active-high
ipreg_data_i  in  NUM_CH*DATA_WIDTH  per-channel input word, channel c at [c*DATA_WIDTH +: DATA_WIDTH]
enable_i  in  NUM_CH  per-channel start request, level-sampled
mode_i  in  NUM_CH*2  per-channel op_e
step_i  in  DATA_WIDTH  addend for OP_ADD, shared by all channels
clear_err_i  in  NUM_CH  per-channel error clear
ipreg_data_o  out  DATA_WIDTH  write-back data
ch_sel_o  out  CH_W  channel index of the write-back
wen_o  out  1  one-cycle write strobe
status_o  out  NUM_CH*2  per-channel status_e
err_o  out  1  OR of all channels in ERROR

Behaviour:
- Reset (synchronous, rst_i=1 at edge): all channels IDLE; ipreg_data_o=0, ch_sel_o=0, wen_o=0; status_o all IDLE; err_o=0; arbiter pointer=NUM_CH-1, so ch0 has first priority. Reset mid-job abandons the job silently.
- Channel FSM, status_e encoding IDLE=0, BUSY=1, DONE=2, ERROR=3.
- IDLE:
  - enable_i[c]=1 at an edge: capture data, mode, step_i and iteration count = BUSY_CYCLES; go to BUSY.
  - If the captured mode is OP_RSVD (3): go directly to ERROR instead.
- BUSY: one op per cycle on the working value.
  - OP_INC(0): x+1. OP_ADD(1): x+step. OP_DEC(2): x-1.
  - Ops are computed at DATA_WIDTH+1 bits. A carry out on INC/ADD or a borrow on DEC sends the channel to ERROR and discards the value; no wrap.
  - After BUSY_CYCLES ops: go to DONE.
- DONE: raise a write request and hold the result until granted; enable_i is ignored. On the grant edge: ipreg_data_o<=result, ch_sel_o<=c, wen_o<=1, channel -> IDLE.
- ERROR: held until clear_err_i[c]=1, then IDLE. enable_i is ignored; enable and clear in the same cycle yields IDLE with no capture.
- Latency, no contention: the capture edge is E; status BUSY after E; DONE after E+BUSY_CYCLES; wen_o high for the one cycle following edge E+BUSY_CYCLES+1, with the channel IDLE at the same time. The earliest re-capture is the next edge.
- Arbiter:
  - Round-robin over DONE channels; at most one grant per cycle.
  - Search starts at pointer+1 modulo NUM_CH; the pointer updates to the granted index.
  - A continuously re-enabling channel cannot starve others: worst-case wait is NUM_CH-1 grants.
- wen_o is a single-cycle pulse, deasserted on every cycle without a grant. ipreg_data_o and ch_sel_o hold their last values between pulses. The sink always accepts (no back-pressure).
- status_o and err_o are combinational decodes of the registered channel states.

Decomposition:
- Package custom_axi_ip_pkg: existing status_e, plus new op_e (OP_INC, OP_ADD, OP_DEC, OP_RSVD, 2-bit).
- Sub-module custom_axi_ip_ch: one channel FSM, working register, iteration counter, overflow detect; exposes req, result, status.
- Top level: generate loop of NUM_CH instances, round-robin arbiter, registered output port.

Test Plan:
1. NUM_CH=4, BUSY_CYCLES=1. ch0: data 0x0000_0010, OP_INC, enable one cycle -> status BUSY, DONE, IDLE; wen_o pulse 2 edges after capture with ipreg_data_o=0x0000_0011, ch_sel_o=0.
2. All four channels enabled in the same cycle with OP_INC, data 0,1,2,3 -> four consecutive wen_o pulses, ch_sel_o 0,1,2,3, data 1,2,3,4; waiting channels report DONE until granted.
3. BUSY_CYCLES=4 build: ch2 data 0x100, OP_ADD, step 0x10 -> result 0x140, wen_o 5 edges after capture, ch_sel_o=2.
4. ch1 data 0xFFFF_FFFF, OP_INC -> ERROR, err_o=1, no wen_o; enable held is ignored; clear_err_i pulse -> IDLE, err_o=0; a new job with data 5 completes as 6.
5. ch3 data 0, OP_DEC -> ERROR. ch0 with mode 3 -> ERROR on the edge after capture with no BUSY cycle. rst_i asserted while ch1 is BUSY -> next cycle all IDLE, wen_o=0, ipreg_data_o=0.
6. Fairness: ch0 re-enabled on every IDLE cycle while ch1 completes once -> ch1 is granted within one grant of becoming DONE; the grant order alternates 0,1.

Source files
------------

// File: rtl/custom_axi_ip_pkg.sv
// Shared types for the multi-channel compute engine: channel status and op encodings.
package custom_axi_ip_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_DONE  = 2'd2,
    ST_ERROR = 2'd3
  } status_e;

  typedef enum logic [1:0] {
    OP_INC  = 2'd0,
    OP_ADD  = 2'd1,
    OP_DEC  = 2'd2,
    OP_RSVD = 2'd3
  } op_e;

endpackage

// File: rtl/custom_axi_ip_ch.sv
// One compute channel: captures a job, iterates the op, flags over/underflow,
// then holds the result and requests write-back until granted.
module custom_axi_ip_ch
  import custom_axi_ip_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned BUSY_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic [1:0]            mode,
  input  logic [DATA_WIDTH-1:0] step,
  input  logic                  clear_err,
  input  logic                  gnt,
  output logic                  req_c,
  output logic [DATA_WIDTH-1:0] result,
  output status_e               status
);

  localparam int unsigned CNT_W = $clog2(BUSY_CYCLES + 1);

  status_e               state_q, state_d;
  op_e                   op_q, op_d;
  logic [DATA_WIDTH-1:0] work_q, work_d;
  logic [DATA_WIDTH-1:0] step_q, step_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH:0]   op_res;

  // One extra bit so carry (INC/ADD) or borrow (DEC) lands in the MSB
  always_comb begin
    op_res = '0;
    unique case (op_q)
      OP_INC:  op_res = {1'b0, work_q} + (DATA_WIDTH+1)'(1);
      OP_ADD:  op_res = {1'b0, work_q} + {1'b0, step_q};
      OP_DEC:  op_res = {1'b0, work_q} - (DATA_WIDTH+1)'(1);
      default: op_res = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    work_d  = work_q;
    step_d  = step_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (enable) begin
          work_d  = data;
          step_d  = step;
          op_d    = op_e'(mode);
          cnt_d   = CNT_W'(BUSY_CYCLES);
          state_d = (op_e'(mode) == OP_RSVD) ? ST_ERROR : ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (op_res[DATA_WIDTH]) begin
          state_d = ST_ERROR;
        end else begin
          work_d = op_res[DATA_WIDTH-1:0];
          cnt_d  = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_d = ST_DONE;
        end
      end
      ST_DONE:  if (gnt) state_d = ST_IDLE;
      ST_ERROR: if (clear_err) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= OP_INC;
      work_q  <= '0;
      step_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      work_q  <= work_d;
      step_q  <= step_d;
      cnt_q   <= cnt_d;
    end
  end

  assign req_c  = (state_q == ST_DONE);
  assign result = work_q;
  assign status = state_q;

endmodule

// File: rtl/custom_axi_ip_mc.sv
// Multi-channel compute engine: NUM_CH channels sharing one registered
// write-back port through a round-robin arbiter.
module custom_axi_ip_mc
  import custom_axi_ip_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned BUSY_CYCLES = 1,
  localparam int unsigned CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [NUM_CH*DATA_WIDTH-1:0] ipreg_data_i,
  input  logic [NUM_CH-1:0]            enable_i,
  input  logic [NUM_CH*2-1:0]          mode_i,
  input  logic [DATA_WIDTH-1:0]        step_i,
  input  logic [NUM_CH-1:0]            clear_err_i,
  output logic [DATA_WIDTH-1:0]        ipreg_data_o,
  output logic [CH_W-1:0]              ch_sel_o,
  output logic                         wen_o,
  output logic [NUM_CH*2-1:0]          status_o,
  output logic                         err_o
);

  logic [NUM_CH-1:0]     req;
  logic [NUM_CH-1:0]     gnt;
  logic [DATA_WIDTH-1:0] result [NUM_CH];
  status_e               ch_status [NUM_CH];
  logic                  gnt_vld;
  logic [CH_W-1:0]       gnt_idx;
  logic [CH_W-1:0]       cand_idx;
  logic [CH_W-1:0]       ptr_q;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    custom_axi_ip_ch #(
      .DATA_WIDTH  (DATA_WIDTH),
      .BUSY_CYCLES (BUSY_CYCLES)
    ) u_ch (
      .clk       (clk_i),
      .rst       (rst_i),
      .enable    (enable_i[c]),
      .data      (ipreg_data_i[c*DATA_WIDTH +: DATA_WIDTH]),
      .mode      (mode_i[c*2 +: 2]),
      .step      (step_i),
      .clear_err (clear_err_i[c]),
      .gnt       (gnt[c]),
      .req_c     (req[c]),
      .result    (result[c]),
      .status    (ch_status[c])
    );
  end

  // Round-robin: scan from the channel after the last grant, wrapping once
  always_comb begin
    gnt      = '0;
    gnt_vld  = 1'b0;
    gnt_idx  = '0;
    cand_idx = '0;
    for (int unsigned i = 1; i <= NUM_CH; i++) begin
      cand_idx = CH_W'((32'(ptr_q) + i) % NUM_CH);
      if (!gnt_vld && req[cand_idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand_idx;
      end
    end
    if (gnt_vld) gnt[gnt_idx] = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ipreg_data_o <= '0;
      ch_sel_o     <= '0;
      wen_o        <= 1'b0;
      ptr_q        <= CH_W'(NUM_CH - 1);
    end else begin
      wen_o <= gnt_vld;
      if (gnt_vld) begin
        ipreg_data_o <= result[gnt_idx];
        ch_sel_o     <= gnt_idx;
        ptr_q        <= gnt_idx;
      end
    end
  end

  always_comb begin
    status_o = '0;
    err_o    = 1'b0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      status_o[c*2 +: 2] = ch_status[c];
      err_o              = err_o | (ch_status[c] == ST_ERROR);
    end
  end

endmodule
